segment_reader: RTL and testbench

SEGMENT_READER -- requirements
Module: segment_reader

---
 rtl/seg_pkg.sv | 42 ++++
 rtl/seg_decode.sv | 21 ++
 rtl/segment_reader.sv | 126 ++++++++++++
 tb/tb_segment_reader.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment constants: hex glyph table (lit=1, gfedcba), reader states
// and the legal range of the stability count.
package seg_pkg;

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    // Indexed by digit value: GLYPH_TBL[d] is the lit pattern for hex digit d.
    localparam logic [15:0][6:0] GLYPH_TBL = {
        GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
        GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
    };

    localparam int STABLE_MIN = 1;
    localparam int STABLE_MAX = 15;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_PENDING = 2'd2
    } state_e;

    // Nibble-to-segment encoder for display drivers, sharing the same glyph table.
    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        return GLYPH_TBL[nib];
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational reverse lookup: lit=1 segment pattern to hex digit plus legality.
module seg_decode
    import seg_pkg::*;
(
    input  logic [6:0] pat_i,
    output logic [3:0] digit_o,
    output logic       legal_o
);

    always_comb begin
        digit_o = 4'd0;
        legal_o = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pat_i == GLYPH_TBL[i]) begin
                digit_o = 4'(i);
                legal_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/segment_reader.sv
// Reads a multiplexed seven-segment display line set and recovers the shown hex
// digit once the pattern has been stable for STABLE_N sample strobes.
module segment_reader
    import seg_pkg::*;
#(
    parameter int STABLE_N   = 3,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clockFPGA,
    input  logic       RES,
    input  logic       sample_en,
    input  logic [6:0] seg_in,
    output logic [3:0] value,
    output logic       valid,
    output logic       error,
    output logic       change,
    output logic [7:0] change_count
);

    localparam int STABLE_C = (STABLE_N < STABLE_MIN) ? STABLE_MIN :
                              (STABLE_N > STABLE_MAX) ? STABLE_MAX : STABLE_N;
    localparam logic [3:0] STABLE_LIM = 4'(STABLE_C);

    logic [6:0] sync1_q, sync2_q, pat;
    logic [6:0] cand_q, cand_d, comm_q, comm_d;
    logic [3:0] cnt_q, cnt_d;
    state_e     state_q, state_d;
    logic       commit_q, commit_d;
    logic [3:0] value_q, value_d;
    logic       valid_q, valid_d, error_q, error_d, change_q, change_d;
    logic [7:0] cc_q, cc_d;
    logic [3:0] dec_digit;
    logic       dec_legal;

    assign pat = ACTIVE_LOW ? ~sync2_q : sync2_q;

    seg_decode u_dec (
        .pat_i   (comm_q),
        .digit_o (dec_digit),
        .legal_o (dec_legal)
    );

    // Candidate tracking and commit decision.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        comm_d   = comm_q;
        state_d  = state_q;
        commit_d = 1'b0;
        if (sample_en) begin
            if (pat != cand_q) begin
                cand_d = pat;
                cnt_d  = 4'd1;
                if (state_q == ST_LOCKED) state_d = ST_PENDING;
            end else if (cnt_q < STABLE_LIM) begin
                cnt_d = cnt_q + 4'd1;
            end
            // A steady LOCKED pattern keeps saturating without re-committing.
            if (cnt_d == STABLE_LIM && !(state_q == ST_LOCKED && pat == cand_q)) begin
                comm_d   = cand_d;
                state_d  = ST_LOCKED;
                commit_d = 1'b1;
            end
        end
    end

    // Output update one clock after the commit, from the decoded committed pattern.
    always_comb begin
        value_d  = value_q;
        valid_d  = valid_q;
        error_d  = error_q;
        cc_d     = cc_q;
        change_d = 1'b0;
        if (commit_q) begin
            if (dec_legal) begin
                value_d = dec_digit;
                valid_d = 1'b1;
                error_d = 1'b0;
                if (dec_digit != value_q || !valid_q) begin
                    change_d = 1'b1;
                    cc_d     = cc_q + 8'd1;
                end
            end else begin
                valid_d = 1'b0;
                error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clockFPGA or posedge RES) begin
        if (RES) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            comm_q   <= '0;
            state_q  <= ST_ACQUIRE;
            commit_q <= 1'b0;
            value_q  <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            change_q <= 1'b0;
            cc_q     <= '0;
        end else begin
            sync1_q  <= seg_in;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            comm_q   <= comm_d;
            state_q  <= state_d;
            commit_q <= commit_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
            change_q <= change_d;
            cc_q     <= cc_d;
        end
    end

    assign value        = value_q;
    assign valid        = valid_q;
    assign error        = error_q;
    assign change       = change_q;
    assign change_count = cc_q;

endmodule

// File: tb/tb_segment_reader.sv
// Directed bench: dut_a (STABLE_N=3, strobe every 4 cycles) and dut_b (STABLE_N=1,
// strobe held high), both active-low segment lines.
module tb_segment_reader;

    logic       clk = 1'b0;
    logic       RES;
    logic       sample_en, sample_en_b;
    logic [6:0] seg_in, seg_b;
    logic [3:0] value, value_b;
    logic       valid, valid_b, error, error_b, change, change_b;
    logic [7:0] cc, cc_b;

    int total = 0;
    int bad   = 0;
    int npulse = 0;

    always #5 clk = ~clk;

    segment_reader #(.STABLE_N(3), .ACTIVE_LOW(1'b1)) dut_a (
        .clockFPGA(clk), .RES(RES), .sample_en(sample_en), .seg_in(seg_in),
        .value(value), .valid(valid), .error(error), .change(change),
        .change_count(cc)
    );

    segment_reader #(.STABLE_N(1), .ACTIVE_LOW(1'b1)) dut_b (
        .clockFPGA(clk), .RES(RES), .sample_en(sample_en_b), .seg_in(seg_b),
        .value(value_b), .valid(valid_b), .error(error_b), .change(change_b),
        .change_count(cc_b)
    );

    // Counts dut_a change pulses; reads the pre-edge value so a 1-cycle pulse counts once.
    always @(posedge clk) if (change) npulse <= npulse + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive pattern then give the 2-flop synchronizer time to settle.
    task automatic set_seg(input logic [6:0] v);
        seg_in = v;
        repeat (2) @(negedge clk);
    endtask

    // One sample strobe inside a 4-cycle period.
    task automatic strobe();
        @(negedge clk); sample_en = 1'b1;
        @(negedge clk); sample_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int p0;
        logic [3:0] prev, nxt;
        RES = 1'b1; sample_en = 1'b0; sample_en_b = 1'b1;
        seg_in = 7'h40; seg_b = 7'h40;
        repeat (3) @(negedge clk);
        chk("rst_value", 32'(value), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_error", 32'(error), 32'h0);
        chk("rst_change", 32'(change), 32'h0);
        chk("rst_count", 32'(cc), 32'h0);
        RES = 1'b0;

        // Digit 0 acquired after the third strobe.
        set_seg(7'h40);
        strobe(); strobe();
        chk("acq_not_yet", 32'(valid), 32'h0);
        strobe();
        chk("acq_value", 32'(value), 32'h0);
        chk("acq_valid", 32'(valid), 32'h1);
        chk("acq_count", 32'(cc), 32'h1);
        chk("acq_pulse", 32'(npulse), 32'h1);

        // One-strobe glitch to '1' is filtered, return to 0 relocks silently.
        set_seg(7'h79);
        strobe();
        chk("glitch_valid", 32'(valid), 32'h1);
        chk("glitch_value", 32'(value), 32'h0);
        set_seg(7'h40);
        strobe(); strobe(); strobe();
        chk("relock_value", 32'(value), 32'h0);
        chk("relock_pulse", 32'(npulse), 32'h1);
        chk("relock_count", 32'(cc), 32'h1);

        // All-dark is illegal: error, value held, count unchanged.
        set_seg(7'h7F);
        strobe(); strobe(); strobe();
        chk("ill_valid", 32'(valid), 32'h0);
        chk("ill_error", 32'(error), 32'h1);
        chk("ill_value", 32'(value), 32'h0);
        chk("ill_count", 32'(cc), 32'h1);
        chk("ill_pulse", 32'(npulse), 32'h1);
        set_seg(7'h24);
        strobe(); strobe(); strobe();
        chk("d2_value", 32'(value), 32'h2);
        chk("d2_valid", 32'(valid), 32'h1);
        chk("d2_error", 32'(error), 32'h0);
        chk("d2_count", 32'(cc), 32'h2);
        chk("d2_pulse", 32'(npulse), 32'h2);

        // 254 more alternating commits: pulse 255 gives count FF, pulse 256 wraps to 0.
        for (int i = 0; i < 254; i++) begin
            set_seg((i % 2 == 0) ? 7'h79 : 7'h24);
            strobe(); strobe(); strobe();
            if (i == 252) chk("wrap_ff", 32'(cc), 32'hFF);
        end
        chk("wrap_zero", 32'(cc), 32'h0);
        chk("wrap_value", 32'(value), 32'h2);
        chk("wrap_pulses", 32'(npulse), 32'd256);

        // Asynchronous reset in PENDING, then restart from zero samples.
        set_seg(7'h40);
        strobe();
        chk("pend_hold", 32'(value), 32'h2);
        @(posedge clk); #2; RES = 1'b1; #1;
        chk("ar_value", 32'(value), 32'h0);
        chk("ar_valid", 32'(valid), 32'h0);
        chk("ar_error", 32'(error), 32'h0);
        chk("ar_change", 32'(change), 32'h0);
        chk("ar_count", 32'(cc), 32'h0);
        @(negedge clk); RES = 1'b0;
        repeat (2) @(negedge clk);
        strobe(); strobe();
        chk("ar_reacq_wait", 32'(valid), 32'h0);
        strobe();
        chk("ar_reacq_value", 32'(value), 32'h0);
        chk("ar_reacq_valid", 32'(valid), 32'h1);
        chk("ar_reacq_count", 32'(cc), 32'h1);

        // dut_b: after release it first commits the reset-time pattern (sync=0 -> all lit = 8),
        // then 0, so it enters the toggle phase showing 0 with two pulses counted.
        chk("b_start_value", 32'(value_b), 32'h0);
        chk("b_start_count", 32'(cc_b), 32'h2);
        prev = 4'h0;
        for (int k = 0; k < 6; k++) begin
            nxt = (k % 2 == 0) ? 4'h1 : 4'h0;
            seg_b = (k % 2 == 0) ? 7'h79 : 7'h40;
            repeat (3) @(negedge clk);
            chk("b_early_value", 32'(value_b), 32'(prev));
            chk("b_early_change", 32'(change_b), 32'h0);
            @(negedge clk);
            chk("b_edge_value", 32'(value_b), 32'(nxt));
            chk("b_edge_change", 32'(change_b), 32'h1);
            @(negedge clk);
            prev = nxt;
        end
        chk("b_end_count", 32'(cc_b), 32'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
